// File: rtl/s_machine.sv
// S-Machine: PC + hard-wired ROM + condition-select branch unit.
// The shipped program computes a half adder of the two switches onto the LEDs.
module s_machine #(
    parameter int ADDR_W      = 4,
    parameter int ROM_DEPTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic enable,
    input  logic switch0,
    input  logic switch1,
    output logic led0,
    output logic led1
);

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_SW0    = 2'b01,
        COND_SW1    = 2'b10,
        COND_NEVER  = 2'b11
    } cond_e;

    typedef struct packed {
        logic [ADDR_W-1:0] next_t;
        logic [ADDR_W-1:0] next_f;
        cond_e             cond;
        logic              out_we;
        logic [1:0]        out_val;
    } rom_word_t;

    function automatic rom_word_t mk(input logic [ADDR_W-1:0] t,
                                     input logic [ADDR_W-1:0] f,
                                     input cond_e             c,
                                     input logic              we,
                                     input logic [1:0]        v);
        rom_word_t w;
        w.next_t  = t;
        w.next_f  = f;
        w.cond    = c;
        w.out_we  = we;
        w.out_val = v;
        return w;
    endfunction

    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic [1:0]             led_q, led_d;
    logic [SYNC_STAGES-1:0] sync0_q, sync1_q;
    rom_word_t              rom [ROM_DEPTH];
    rom_word_t              word;
    logic                   sw0_s, sw1_s;
    logic                   cond_true;

    assign sw0_s = sync0_q[SYNC_STAGES-1];
    assign sw1_s = sync1_q[SYNC_STAGES-1];

    // Unused words all jump back to 0 so a corrupted PC recovers within one cycle.
    always_comb begin
        for (int i = 0; i < ROM_DEPTH; i++) begin
            rom[i] = mk(ADDR_W'(0), ADDR_W'(0), COND_ALWAYS, 1'b0, 2'b00);
        end
        rom[0] = mk(ADDR_W'(1), ADDR_W'(2), COND_SW0,    1'b0, 2'b00);
        rom[1] = mk(ADDR_W'(3), ADDR_W'(4), COND_SW1,    1'b0, 2'b00);
        rom[2] = mk(ADDR_W'(4), ADDR_W'(5), COND_SW1,    1'b0, 2'b00);
        rom[3] = mk(ADDR_W'(0), ADDR_W'(0), COND_ALWAYS, 1'b1, 2'b10);
        rom[4] = mk(ADDR_W'(0), ADDR_W'(0), COND_ALWAYS, 1'b1, 2'b01);
        rom[5] = mk(ADDR_W'(0), ADDR_W'(0), COND_ALWAYS, 1'b1, 2'b00);
    end

    assign word = rom[pc_q];

    always_comb begin
        cond_true = 1'b0;
        unique case (word.cond)
            COND_ALWAYS: cond_true = 1'b1;
            COND_SW0:    cond_true = sw0_s;
            COND_SW1:    cond_true = sw1_s;
            COND_NEVER:  cond_true = 1'b0;
        endcase
    end

    always_comb begin
        pc_d  = cond_true ? word.next_t : word.next_f;
        led_d = word.out_we ? word.out_val : led_q;
    end

    always_ff @(posedge clk) begin
        if (!enable) begin
            pc_q    <= '0;
            led_q   <= 2'b00;
            sync0_q <= '0;
            sync1_q <= '0;
        end else begin
            pc_q    <= pc_d;
            led_q   <= led_d;
            sync0_q <= (sync0_q << 1) | SYNC_STAGES'(switch0);
            sync1_q <= (sync1_q << 1) | SYNC_STAGES'(switch1);
        end
    end

    assign led0 = led_q[0];
    assign led1 = led_q[1];

endmodule

// File: tb/tb_s_machine.sv
// Self-checking bench for s_machine: expected LEDs come from the half-adder
// truth {A&B, A^B} once the switches have been stable for the settle window.
module tb_s_machine;

    localparam int SETTLE = 8;

    logic clk = 1'b0;
    logic enable = 1'b0;
    logic switch0 = 1'b0;
    logic switch1 = 1'b0;
    logic led0, led1;

    int errs = 0;
    int checks = 0;

    s_machine dut (
        .clk    (clk),
        .enable (enable),
        .switch0(switch0),
        .switch1(switch1),
        .led0   (led0),
        .led1   (led1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] half_add(input bit a, input bit b);
        return {a & b, a ^ b};
    endfunction

    task automatic check_pc_range(input string tag);
        chk(tag, 32'(dut.pc_q <= 4'd5), 32'd1);
    endtask

    // Apply switches, skip the settle window, then require the model value every cycle.
    task automatic apply_and_hold(input bit a, input bit b, input int hold, input string tag);
        switch0 = a;
        switch1 = b;
        repeat (SETTLE) begin
            @(negedge clk);
            check_pc_range({tag, "_pc"});
        end
        chk({tag, "_settled"}, 32'({led1, led0}), 32'(half_add(a, b)));
        repeat (hold) begin
            @(negedge clk);
            chk({tag, "_hold"}, 32'({led1, led0}), 32'(half_add(a, b)));
            check_pc_range({tag, "_pc"});
        end
    endtask

    initial begin
        bit a, b;
        int gap;

        enable  = 1'b0;
        switch0 = 1'b0;
        switch1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_leds", 32'({led1, led0}), 32'd0);
        chk("rst_pc", 32'(dut.pc_q), 32'd0);
        repeat (10) begin
            @(negedge clk);
            chk("rst_hold_leds", 32'({led1, led0}), 32'd0);
        end

        enable = 1'b1;
        repeat (100) begin
            @(negedge clk);
            chk("run00_leds", 32'({led1, led0}), 32'd0);
            check_pc_range("run00_pc");
        end

        apply_and_hold(1'b1, 1'b0, 1000, "sw10");
        apply_and_hold(1'b0, 1'b1, 20, "sw01");
        apply_and_hold(1'b1, 1'b1, 20, "sw11");

        // Drop enable mid-pass; reset must clear LEDs and PC on the very next edge.
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("midrst_leds", 32'({led1, led0}), 32'd0);
        chk("midrst_pc", 32'(dut.pc_q), 32'd0);
        enable = 1'b1;
        repeat (SETTLE) @(negedge clk);
        chk("rerun_leds", 32'({led1, led0}), 32'(half_add(1'b1, 1'b1)));

        for (int i = 0; i < 20; i++) begin
            a   = 1'($urandom_range(0, 1));
            b   = 1'($urandom_range(0, 1));
            gap = int'($urandom_range(50, 500));
            apply_and_hold(a, b, gap - SETTLE, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/s_machine.md
Name: s_machine

Overview:
- Minimal sequencer CPU (S-Machine) built from a program counter, a hard-wired program ROM and a condition-select branch unit.
- Each cycle it executes one ROM word: optionally writes the two LEDs, tests one condition, and branches to one of two next addresses.
- The shipped ROM program implements a half adder: led0 = switch0 XOR switch1 (sum), led1 = switch0 AND switch1 (carry).
- Top-level block driven directly by board clock, enable and two switches.

Parameters:
- ADDR_W, 4, PC / ROM address width.
- ROM_DEPTH, 16, number of ROM words (2**ADDR_W).
- SYNC_STAGES, 2, synchronizer flops on each switch input.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- enable  input  1  reset: synchronous, active-low. Low at a clk edge resets the machine; high lets it run.
- switch0  input  1  asynchronous switch input, operand A.
- switch1  input  1  asynchronous switch input, operand B.
- led0  output  1  registered LED output, sum bit.
- led1  output  1  registered LED output, carry bit.

Behaviour:
- Reset (enable=0 at posedge clk): pc=0, led0=0, led1=0, synchronizer flops=0. Reset dominates everything else.
- Before enable is first driven (X/undefined), outputs are don't-care. Once enable=0 has been sampled for at least one edge, outputs are 0.
- Input sync: each switch passes through SYNC_STAGES flops. Conditions test only the synchronized values sw0_s / sw1_s.
- ROM word fields: next_t[ADDR_W], next_f[ADDR_W], cond[2], out_we[1], out_val[2].
- cond encoding: 00 = always true; 01 = sw0_s; 10 = sw1_s; 11 = never true.
- Per cycle when running:
  - pc <= (cond true) ? next_t : next_f.
  - If out_we, then {led1,led0} <= out_val; otherwise the LEDs hold.
- ROM is combinational and indexed by pc. All outputs are registered and glitch-free.
- Half-adder program:
  - 0: cond=01, T->1, F->2, out_we=0.
  - 1 (A=1): cond=10, T->3, F->4, out_we=0.
  - 2 (A=0): cond=10, T->4, F->5, out_we=0.
  - 3: out=10 (led1=1, led0=0), cond=00, ->0.
  - 4: out=01 (led1=0, led0=1), cond=00, ->0.
  - 5: out=00, cond=00, ->0.
  - 6..ROM_DEPTH-1: out_we=0, cond=00, ->0 (recovery to start).
- Loop period is exactly 3 cycles. A and B are sampled in different cycles of the same pass, so a switch change mid-pass may produce one transitional result, which is corrected on the next pass.
- Latency: a stable switch change is reflected on the LEDs within SYNC_STAGES + 6 = 8 clk cycles.
- Reset mid-program: at the reset edge, pc returns to 0 and LEDs clear to 0 regardless of the current state. Execution resumes from address 0 on the first edge with enable=1.
- PC wraps modulo ROM_DEPTH. No instruction targets an address outside the ROM.

Test Plan:
- Reset: enable=0 for 2 cycles, switches=00 -> led1=0, led0=0, pc=0; hold enable=0 for 10 cycles -> outputs stay 0.
- Release enable=1 with switches=00, run 100 cycles -> led1=0, led0=0 throughout.
- switch0=1, switch1=0; wait 8 cycles -> led0=1, led1=0, stable for 1000 cycles.
- switch0=0, switch1=1; wait 8 cycles -> led0=1, led1=0.
- switch0=1, switch1=1; wait 8 cycles -> led0=0, led1=1. Then drop enable=0 mid-loop -> next edge led0=0, led1=0; re-enable -> led1=1 again within 8 cycles.
- Random switch toggles every 50-500 cycles -> after each change settles (8 cycles), {led1,led0} equals {A&B, A^B}; pc never leaves the range 0..5.
